// File: rtl/mux4_rr_arbiter_if.sv
// Bundle of the four requester lanes and the shared single-lane output of the 4:1 mux arbiter.
// The master side is the requesters and the consumer; the slave side is the arbiter.
interface mux4_rr_arbiter_if #(
   parameter int unsigned DW = 8
);
   logic [3:0]      req;
   logic [3:0]      last;
   logic [4*DW-1:0] din;
   logic [3:0]      gnt;
   logic [1:0]      sel;
   logic [DW-1:0]   dout;
   logic            dout_valid;
   logic            busy;

   modport master (
      output req,
      output last,
      output din,
      input  gnt,
      input  sel,
      input  dout,
      input  dout_valid,
      input  busy
   );

   modport slave (
      input  req,
      input  last,
      input  din,
      output gnt,
      output sel,
      output dout,
      output dout_valid,
      output busy
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one 4:1 lane mux among four requesters, forwarding the
// granted lane's beats as registered data and bounding each grant by last or a hold count.
module mux4_rr_arbiter #(
   parameter int unsigned DW       = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input logic             clk,
   input logic             rst_n,
   mux4_rr_arbiter_if.slave bus
);

   localparam int unsigned CntW = $clog2(MAX_HOLD) + 1;

   typedef enum logic [0:0] {
      StIdle,
      StGrant
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      gnt_q, gnt_d;
   logic [1:0]      sel_q, sel_d;
   logic [DW-1:0]   dout_q, dout_d;
   logic            dout_valid_q, dout_valid_d;

   logic [1:0]      win;
   logic [DW-1:0]   lane_data;
   logic            at_max;
   logic            grant_end;

   // First requesting lane searched upward from ptr, wrapping mod 4.
   function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      logic       found;
      pick  = p;
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = p + 2'(i);
         if (!found && r[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   endfunction

   assign win       = pick(bus.req, ptr_q);
   assign lane_data = bus.din[sel_q*DW +: DW];
   assign at_max    = (cnt_q == CntW'(MAX_HOLD - 1));

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      gnt_d        = gnt_q;
      sel_d        = sel_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      grant_end    = 1'b0;

      unique case (state_q)
         StIdle: begin
            gnt_d = '0;
            cnt_d = '0;
            if (|bus.req) begin
               state_d = StGrant;
               gnt_d   = 4'b0001 << win;
               sel_d   = win;
            end
         end
         StGrant: begin
            if (bus.req[sel_q]) begin
               dout_d       = lane_data;
               dout_valid_d = 1'b1;
               cnt_d        = cnt_q + CntW'(1);
               grant_end    = bus.last[sel_q] || at_max;
            end else begin
               // Requester went away: release without taking a beat.
               grant_end = 1'b1;
            end
            if (grant_end) begin
               state_d = StIdle;
               gnt_d   = '0;
               cnt_d   = '0;
               ptr_d   = sel_q + 2'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         ptr_q        <= '0;
         cnt_q        <= '0;
         gnt_q        <= '0;
         sel_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         gnt_q        <= gnt_d;
         sel_q        <= sel_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.sel        = sel_q;
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.busy       = (state_q == StGrant);

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: per-cycle grant checks plus a beat scoreboard.
module tb_mux4_rr_arbiter;

   logic clk;
   logic rst_n;

   mux4_rr_arbiter_if #(.DW(8)) bus ();

   mux4_rr_arbiter #(
      .DW      (8),
      .MAX_HOLD(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   logic [1:0] exp_sel = 2'd0;
   logic [7:0] last_dout = 8'h00;

   function automatic logic [31:0] lanes(input logic [7:0] b);
      lanes = {b + 8'd3, b + 8'd2, b + 8'd1, b};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, expect gnt eg after the edge and a beat from lane elane if ev.
   task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic [7:0] base,
                      input logic [3:0] eg, input logic ev, input logic [1:0] elane);
      logic [7:0] exp_d;
      bus.req  = r;
      bus.last = l;
      bus.din  = lanes(base);
      if (ev) exp_q.push_back(base + {6'd0, elane});
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (eg[i]) exp_sel = 2'(i);
      check("gnt", {28'd0, bus.gnt}, {28'd0, eg});
      check("sel", {30'd0, bus.sel}, {30'd0, exp_sel});
      check("busy", {31'd0, bus.busy}, {31'd0, (eg != 4'd0)});
      check("dout_valid", {31'd0, bus.dout_valid}, {31'd0, ev});
      if (ev) begin
         exp_d = exp_q.pop_front();
         check("dout", {24'd0, bus.dout}, {24'd0, exp_d});
         last_dout = exp_d;
      end else begin
         check("dout_hold", {24'd0, bus.dout}, {24'd0, last_dout});
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      bus.req  = 4'hF;
      bus.last = 4'hF;
      bus.din  = lanes(8'h10);
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt", {28'd0, bus.gnt}, 32'd0);
      check("rst_sel", {30'd0, bus.sel}, 32'd0);
      check("rst_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_dout", {24'd0, bus.dout}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fairness: all lanes request single-beat bursts; order 0,1,2,3,0.
      cyc(4'hF, 4'hF, 8'h20, 4'b0001, 1'b0, 2'd0);
      cyc(4'hF, 4'hF, 8'h20, 4'b0000, 1'b1, 2'd0);
      cyc(4'hF, 4'hF, 8'h30, 4'b0010, 1'b0, 2'd0);
      cyc(4'hF, 4'hF, 8'h30, 4'b0000, 1'b1, 2'd1);
      cyc(4'hF, 4'hF, 8'h40, 4'b0100, 1'b0, 2'd0);
      cyc(4'hF, 4'hF, 8'h40, 4'b0000, 1'b1, 2'd2);
      cyc(4'hF, 4'hF, 8'h50, 4'b1000, 1'b0, 2'd0);
      cyc(4'hF, 4'hF, 8'h50, 4'b0000, 1'b1, 2'd3);
      cyc(4'hF, 4'hF, 8'h60, 4'b0001, 1'b0, 2'd0);
      cyc(4'hF, 4'hF, 8'h60, 4'b0000, 1'b1, 2'd0);
      cyc(4'h0, 4'h0, 8'h00, 4'b0000, 1'b0, 2'd0);

      // Single lane 2: A1, A2, A3 with last on the third beat.
      cyc(4'b0100, 4'b0000, 8'h9F, 4'b0100, 1'b0, 2'd0);
      cyc(4'b0100, 4'b0000, 8'h9F, 4'b0100, 1'b1, 2'd2);
      cyc(4'b0100, 4'b0000, 8'hA0, 4'b0100, 1'b1, 2'd2);
      cyc(4'b0100, 4'b0100, 8'hA1, 4'b0000, 1'b1, 2'd2);
      cyc(4'h0, 4'h0, 8'h00, 4'b0000, 1'b0, 2'd0);

      // Drop mid-burst: lane 0 takes 2 beats then drops; lane 2 follows.
      cyc(4'b0101, 4'b0000, 8'h70, 4'b0001, 1'b0, 2'd0);
      cyc(4'b0101, 4'b0000, 8'h70, 4'b0001, 1'b1, 2'd0);
      cyc(4'b0101, 4'b0000, 8'h74, 4'b0001, 1'b1, 2'd0);
      cyc(4'b0100, 4'b0000, 8'h78, 4'b0000, 1'b0, 2'd0);
      cyc(4'b0100, 4'b0000, 8'h80, 4'b0100, 1'b0, 2'd0);
      cyc(4'b0100, 4'b0100, 8'h80, 4'b0000, 1'b1, 2'd2);
      cyc(4'h0, 4'h0, 8'h00, 4'b0000, 1'b0, 2'd0);

      // Rotate pointer to lane 1 with one lane-0 beat.
      cyc(4'b0001, 4'b0001, 8'h88, 4'b0001, 1'b0, 2'd0);
      cyc(4'b0001, 4'b0001, 8'h88, 4'b0000, 1'b1, 2'd0);

      // Hold limit: lanes 1 and 3 never assert last; 4 beats each, alternating.
      cyc(4'b1010, 4'b0000, 8'h90, 4'b0010, 1'b0, 2'd0);
      cyc(4'b1010, 4'b0000, 8'h90, 4'b0010, 1'b1, 2'd1);
      cyc(4'b1010, 4'b0000, 8'h94, 4'b0010, 1'b1, 2'd1);
      cyc(4'b1010, 4'b0000, 8'h98, 4'b0010, 1'b1, 2'd1);
      cyc(4'b1010, 4'b0000, 8'h9C, 4'b0000, 1'b1, 2'd1);
      cyc(4'b1010, 4'b0000, 8'hB0, 4'b1000, 1'b0, 2'd0);
      cyc(4'b1010, 4'b0000, 8'hB0, 4'b1000, 1'b1, 2'd3);
      cyc(4'b1010, 4'b0000, 8'hB4, 4'b1000, 1'b1, 2'd3);
      cyc(4'b1010, 4'b0000, 8'hB8, 4'b1000, 1'b1, 2'd3);
      cyc(4'b1010, 4'b0000, 8'hBC, 4'b0000, 1'b1, 2'd3);
      cyc(4'b1010, 4'b0000, 8'hC0, 4'b0010, 1'b0, 2'd0);
      cyc(4'b0000, 4'b0000, 8'hC0, 4'b0000, 1'b0, 2'd0);

      // Reset during the second beat of a lane-3 burst.
      cyc(4'b1000, 4'b0000, 8'hD0, 4'b1000, 1'b0, 2'd0);
      cyc(4'b1000, 4'b0000, 8'hD0, 4'b1000, 1'b1, 2'd3);
      bus.req = 4'b1000;
      bus.din = lanes(8'hE0);
      #3;
      rst_n = 1'b0;
      #1;
      exp_sel   = 2'd0;
      last_dout = 8'h00;
      check("midrst_gnt", {28'd0, bus.gnt}, 32'd0);
      check("midrst_sel", {30'd0, bus.sel}, 32'd0);
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check("midrst_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
      check("midrst_dout", {24'd0, bus.dout}, 32'd0);
      @(posedge clk);
      #1;
      check("midrst_hold_valid", {31'd0, bus.dout_valid}, 32'd0);
      check("midrst_hold_gnt", {28'd0, bus.gnt}, 32'd0);
      bus.req = 4'b1001;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(4'b1001, 4'b0000, 8'hF0, 4'b0001, 1'b0, 2'd0);
      cyc(4'b1001, 4'b1001, 8'hF0, 4'b0000, 1'b1, 2'd0);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
